data_memory_be: RTL
===================

// Module: data_memory_be
// PURPOSE
//  Byte-addressable data memory for the processor datapath: a parametrised successor to the word-only data memory.
//  Adds byte/half/word/double accesses with byte-lane write enables and sign/zero-extended loads.
//  Adds a 1-cycle registered read with a valid strobe, misalignment/range fault reporting and clear-on-reset sequencing.
//  Sits between the ALU address output and the write-back mux; driven by MemRead/MemWrite from the control unit.
// PARAMETERS
//  W               32   data width in bits; legal values 32 or 64
//  N               64   depth in W-bit words
//  CLEAR_ON_RESET  1    1: zero all N words after reset (INIT state); 0: skip INIT, contents undefined
//  ADDR_W (local)  $clog2(N*W/8)  byte-address width
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       reset, asynchronous, active-low
//  address      in   ADDR_W  byte address; word index = address[ADDR_W-1:$clog2(W/8)]
//  MemRead      in   1       load request, sampled on the rising edge of clk
//  MemWrite     in   1       store request, sampled on the rising edge of clk; has priority over MemRead
//  size         in   2       00 byte, 01 half, 10 word, 11 double (legal only when W=64)
//  is_unsigned  in   1       load: 1 zero-extend, 0 sign-extend; ignored for stores
//  write_data   in   W       store data, right-aligned (LSBs)
//  read_data    out  W       extended load result, registered
//  read_valid   out  1       1-cycle pulse: read_data holds a new load result
//  fault        out  1       1-cycle pulse: the request was misaligned, out of range or used an illegal size
//  init_busy    out  1       1 while the INIT clear sequence is running; requests ignored
// BEHAVIOUR
//  Reset (rst=0, async): read_data=0, read_valid=0, fault=0, init_idx=0.
//   init_busy=CLEAR_ON_RESET; FSM->INIT if CLEAR_ON_RESET else READY. Memory array is not reset directly.
//  FSM INIT: writes 0 to mem[init_idx] each cycle, init_idx++.
//   After writing word N-1: -> READY, init_busy=0 on the following cycle (INIT lasts exactly N cycles).
//   MemRead/MemWrite during INIT: ignored; no read_valid, no fault, no write.
//   Reset asserted mid-INIT: restarts at init_idx=0.
//  FSM READY: one access per cycle, no back-pressure.
//  Checks per request, in order:
//   illegal: size=11 with W=32
//   misaligned: half with addr[0]!=0; word with addr[1:0]!=0; double with addr[2:0]!=0
//   range: word index >= N (possible only when N is not a power of 2)
//   Any failure -> fault=1 next cycle; memory unchanged; read_valid=0; read_data holds its previous value.
//  Store (MemWrite=1, legal): byte-lane enables derived from size and low address bits.
//   write_data is shifted to the addressed lanes; only the enabled bytes of mem[idx] update at the clock edge. No response strobe.
//  Load (MemRead=1, MemWrite=0, legal): next cycle read_data = selected field of mem[idx], extended per is_unsigned; read_valid=1.
//  MemRead & MemWrite together: store only; read dropped, read_valid=0.
//  Neither asserted: read_data holds its value; read_valid=0, fault=0.
//  Load of a word stored in the previous cycle returns the new data (array updates at the edge; no bypass needed).
//  W=32, size=10 is a full word: extension is a no-op.
// STRUCTURE
//  data_mem_pkg: enum mem_size_e {SZ_B, SZ_H, SZ_W, SZ_D}.
//   Also: function byte_en(size, addr_lsbs), returns W/8-bit lane mask; function misaligned(size, addr_lsbs).
//  Sub-module mem_load_align: combinational; raw word + addr_lsbs + size + is_unsigned -> extended result.
//   Reused later by the cache path.
//  Top: INIT/READY FSM, init counter, byte-enabled array write, registered read/valid/fault.
// TESTING
//  1 Reset, CLEAR_ON_RESET=1, N=64: init_busy=1 for 64 cycles, then 0.
//    Loads at 0x00 and 0xFC return 0 with read_valid=1.
//  2 SW 0xDEADBEEF @0x10; LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE.
//    LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
//  3 SW 0x11223344 @0x20; SB 0xAA @0x21; SH 0x5566 @0x22; LW @0x20 -> 0x5566AA44.
//  4 LW @0x22 -> fault=1, read_valid=0, read_data unchanged.
//    SH 0xFFFF @0x21 -> fault=1, LW @0x20 still 0x5566AA44.
//    W=32, size=11 -> fault=1.
//  5 MemRead=MemWrite=1 (SW 0x0BADF00D @0x30): read_valid=0, LW @0x30 next -> 0x0BADF00D.
//    Request during INIT -> no read_valid, no fault, no write.
//  6 rst pulsed low at INIT cycle 20: init restarts, 64 full cycles.
//    W=64: SD then LD @0x08 round-trips 0x0123456789ABCDEF.

Source files
------------

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared access-size encoding, FSM states and lane helpers for the byte-enabled data memory.
package data_mem_pkg;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_e;
    typedef enum logic {ST_INIT, ST_READY} mem_state_e;

    // Lane mask for up to 8 byte lanes; narrower memories truncate it.
    function automatic logic [7:0] byte_en(input mem_size_e s, input logic [2:0] lsbs);
        return ((s == SZ_D) ? 8'hFF : (s == SZ_W) ? 8'h0F : (s == SZ_H) ? 8'h03 : 8'h01) << lsbs;
    endfunction

    function automatic logic misaligned(input mem_size_e s, input logic [2:0] lsbs);
        return (s == SZ_H && lsbs[0]) || (s == SZ_W && |lsbs[1:0]) || (s == SZ_D && |lsbs);
    endfunction
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: extracts the addressed byte/half/word/double from a raw memory word
// and sign- or zero-extends it to the full data width.
module mem_load_align
    import data_mem_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] i_word,
    input  logic [2:0]   i_lsbs,
    input  mem_size_e    i_size,
    input  logic         i_unsigned,
    output logic [W-1:0] o_data
);
    logic [W-1:0] w_sh;
    logic [W-1:0] w_mask;
    logic         w_sign;

    always_comb begin
        w_sh   = i_word >> {i_lsbs, 3'b000};
        w_mask = (i_size == SZ_B) ? W'(8'hFF) :
                 (i_size == SZ_H) ? W'(16'hFFFF) :
                 (i_size == SZ_W) ? W'(32'hFFFF_FFFF) : '1;
        w_sign = !i_unsigned && ((i_size == SZ_B) ? w_sh[7] :
                                 (i_size == SZ_H) ? w_sh[15] :
                                 (i_size == SZ_W) ? w_sh[31] : 1'b0);
        o_data = (w_sh & w_mask) | (w_sign ? ~w_mask : '0);
    end
endmodule

// File: rtl/data_memory_be.sv
// data_memory_be: byte-addressable data memory with lane-enabled stores, extended registered loads,
// fault reporting and an optional clear-after-reset sequence.
module data_memory_be
    import data_mem_pkg::*;
#(
    parameter  int W              = 32,
    parameter  int N              = 64,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int ADDR_W         = $clog2(N * W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [W-1:0]      write_data,
    output logic [W-1:0]      read_data,
    output logic              read_valid,
    output logic              fault,
    output logic              init_busy
);
    localparam int NB    = W / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = ADDR_W - LSB;

    logic [W-1:0]     r_mem [N];
    mem_state_e       r_state, w_state_nxt;
    logic [IDX_W-1:0] r_init_idx, w_init_idx_nxt;
    logic [W-1:0]     r_read_data;
    logic             r_read_valid, r_fault;

    mem_size_e        w_size;
    logic [2:0]       w_lsbs;
    logic [IDX_W-1:0] w_idx;
    logic             w_ready, w_bad, w_fault, w_store, w_load;
    logic [NB-1:0]    w_be;
    logic [W-1:0]     w_wsh, w_ld_data;

    assign w_size  = mem_size_e'(size);
    assign w_lsbs  = 3'(address[LSB-1:0]);
    assign w_idx   = address[ADDR_W-1:LSB];
    assign w_ready = (r_state == ST_READY);
    assign w_bad   = (W == 32 && w_size == SZ_D) || misaligned(w_size, w_lsbs) || int'(w_idx) >= N;
    assign w_fault = w_ready && (MemRead || MemWrite) && w_bad;
    assign w_store = w_ready && MemWrite && !w_bad;
    assign w_load  = w_ready && MemRead && !MemWrite && !w_bad;
    assign w_be    = NB'(byte_en(w_size, w_lsbs));
    assign w_wsh   = write_data << {w_lsbs, 3'b000};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
            r_init_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_idx <= w_init_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_idx_nxt = r_init_idx;
        if (r_state == ST_INIT) begin
            w_init_idx_nxt = r_init_idx + IDX_W'(1);
            if (r_init_idx == IDX_W'(N - 1)) w_state_nxt = ST_READY;
        end
    end

    // The array has no reset of its own; INIT clears it one word per cycle.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) r_mem[r_init_idx] <= '0;
        else if (w_store)
            for (int i = 0; i < NB; i++)
                if (w_be[i]) r_mem[w_idx][i*8 +: 8] <= w_wsh[i*8 +: 8];
    end

    mem_load_align #(.W(W)) u_align (
        .i_word     (r_mem[w_idx]),
        .i_lsbs     (w_lsbs),
        .i_size     (w_size),
        .i_unsigned (is_unsigned),
        .o_data     (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_read_valid <= w_load;
            r_fault      <= w_fault;
            if (w_load) r_read_data <= w_ld_data;
        end
    end

    assign read_data  = r_read_data;
    assign read_valid = r_read_valid;
    assign fault      = r_fault;
    assign init_busy  = (r_state == ST_INIT);
endmodule
